shift_add_controller: RTL

- Sequencer and product register for the unsigned shift-add 32x32 multiplier.
- Sits directly downstream of the Multiplicand register and consumes its `multiplicand_out`.
- Drives that register's `w_ctrl_Multiplicand` load strobe.
- Holds the 64-bit product and runs one add/shift iteration per clock.
- Signals completion with a `done` pulse.

---
 rtl/shift_add_controller.sv | 79 +++++++
 1 files changed

// File: rtl/shift_add_controller.sv
// Sequencer and product register for an unsigned shift-add multiplier.
// Runs one add/shift iteration per clock and pulses done when the product is ready.
module shift_add_controller #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplier_in,
  input  logic [WIDTH-1:0]     multiplicand,
  output logic                 w_ctrl_Multiplicand,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // state | meaning
  // IDLE  | waiting for start, product holds the last result
  // LOAD  | strobe the Multiplicand register for one cycle
  // CALC  | one add/shift iteration per clock, WIDTH iterations
  // DONE  | one-cycle completion pulse, product valid
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     sum;

  always_comb begin
    state_d   = state_q;
    product_d = product_q;
    cnt_d     = cnt_q;
    sum       = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          product_d = {{WIDTH{1'b0}}, multiplier_in};
          cnt_d     = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: state_d = S_CALC;
      S_CALC: begin
        // carry of the upper-half add shifts into the product MSB
        sum       = {1'b0, product_q[2*WIDTH-1:WIDTH]} +
                    (product_q[0] ? {1'b0, multiplicand} : {(WIDTH+1){1'b0}});
        product_d = {sum, product_q[WIDTH-1:1]};
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      product_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
    end
  end

  assign w_ctrl_Multiplicand = (state_q == S_LOAD);
  assign busy                = (state_q != S_IDLE);
  assign done                = (state_q == S_DONE);
  assign product             = product_q;

endmodule
